// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: fetch vs mem stage, registered handshake.
// Define MEM_ARB_RR_EN for round-robin instead of fixed data priority.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW             = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISERV,
    DSERV,
    DONE
  } state_t;

  state_t        r_state, w_state;
  logic          r_mem_req, w_mem_req;
  logic          r_mem_we, w_mem_we;
  logic [AW-1:0] r_mem_addr, w_mem_addr;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata;
  logic [DW-1:0] r_i_rdata, w_i_rdata;
  logic [DW-1:0] r_d_rdata, w_d_rdata;
  logic          r_i_ready, w_i_ready;
  logic          r_d_ready, w_d_ready;
  logic          r_bus_err, w_bus_err;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [DW-1:0] w_rd;
  logic          w_tmo;
  logic          w_pick_d;
  logic          w_pick_i;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  assign w_pick_d = d_req & (~i_req | ~r_last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b1;
    end else if (r_state == IDLE && (d_req || i_req)) begin
      r_last_d <= w_pick_d;
    end
  end
`else
  assign w_pick_d = d_req;
`endif

  assign w_pick_i = i_req & ~w_pick_d;
  assign w_tmo    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state     = r_state;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_i_ready   = 1'b0;
    w_d_ready   = 1'b0;
    w_bus_err   = r_bus_err;
    w_cnt       = r_cnt;
    w_rd        = mem_ack ? mem_rdata : '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_state     = DSERV;
          w_mem_req   = 1'b1;
          w_mem_we    = d_we;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
        end else if (w_pick_i) begin
          w_state    = ISERV;
          w_mem_req  = 1'b1;
          w_mem_we   = 1'b0;
          w_mem_addr = i_addr;
        end
      end
      ISERV, DSERV: begin
        if (mem_ack || w_tmo) begin
          w_state   = DONE;
          w_mem_req = 1'b0;
          w_mem_we  = 1'b0;
          w_cnt     = '0;
          w_bus_err = r_bus_err | ~mem_ack;
          if (r_state == ISERV) begin
            w_i_ready = 1'b1;
            w_i_rdata = w_rd;
          end else begin
            w_d_ready = 1'b1;
            if (!r_mem_we) w_d_rdata = w_rd;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_bus_err   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_i_ready   <= w_i_ready;
      r_d_ready   <= w_d_ready;
      r_bus_err   <= w_bus_err;
      r_cnt       <= w_cnt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign bus_err   = r_bus_err;
  assign i_stall   = i_req & ~r_i_ready;
  assign d_stall   = d_req & ~r_d_ready;

endmodule
